// File: rtl/unstripe_ctrl.sv
// unstripe_ctrl: sequencing controller for the two-lane byte un-striping
// datapath. It waits for lane alignment, then drives the registered lane
// select and the merged valid for the clk_2f mux register. A sticky error
// state catches misalignment and lane loss, and a wrapping counter tracks
// the merged words.
// Optional build macro: UNSTRIPE_CTRL_ERRCNT_EN adds an 8-bit saturating
// err_cnt output that counts entries into the error state.
module unstripe_ctrl #(
  parameter int ALIGN_CYCLES = 2,
  parameter int SKEW_MAX     = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  logic             valid_0,
  input  logic             valid_1,
  input  logic             err_clr,
  output logic             sel,
  output logic             valid_out,
  output logic             active,
  output logic             err_misalign,
  output logic [CNT_W-1:0] word_cnt,
  output logic [1:0]       state
`ifdef UNSTRIPE_CTRL_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  // align counter only ever needs to reach SKEW_MAX
  localparam int ACW = (SKEW_MAX < 1) ? 1 : $clog2(SKEW_MAX + 1);
  localparam logic [ACW-1:0] ALIGN_TH = ACW'(ALIGN_CYCLES);
  localparam logic [ACW-1:0] SKEW_TH  = ACW'(SKEW_MAX);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               sel_r;
  logic               sel_nxt_s;
  logic               vout_r;
  logic               vout_nxt_s;
  logic [ACW-1:0]     align_cnt_r;
  logic [ACW-1:0]     align_nxt_s;
  logic [CNT_W-1:0]   word_cnt_r;
  logic               active_r;
  logic               err_r;

  // Saturating 8-bit increment used by the error counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    if (val == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = val + 8'd1;
    end
  endfunction

  // Next-state, next-select and next-valid decode from the lane valids
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = 1'b0;
    vout_nxt_s  = 1'b0;
    align_nxt_s = align_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_0) begin
          state_nxt_s = ST_ALIGN;
          align_nxt_s = {{(ACW-1){1'b0}}, 1'b1};
        end else if (valid_1) begin
          state_nxt_s = ST_ERROR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (!valid_0 && !valid_1) begin
          state_nxt_s = ST_IDLE;
        end else if (!valid_0) begin
          // lane 1 running without lane 0 is a misalignment
          state_nxt_s = ST_ERROR;
        end else if ((align_cnt_r >= ALIGN_TH) && valid_1) begin
          state_nxt_s = ST_ACTIVE;
        end else if (align_cnt_r == SKEW_TH) begin
          state_nxt_s = ST_ERROR;
        end else begin
          align_nxt_s = align_cnt_r + {{(ACW-1){1'b0}}, 1'b1};
        end
      end
      ST_ACTIVE: begin
        if (!sel_r) begin
          if (!valid_0 && !valid_1) begin
            // clean end on a pair boundary
            state_nxt_s = ST_IDLE;
          end else if (!valid_0) begin
            state_nxt_s = ST_ERROR;
          end else begin
            sel_nxt_s  = 1'b1;
            vout_nxt_s = 1'b1;
          end
        end else begin
          if (!valid_1) begin
            // second half of the pair missing
            state_nxt_s = ST_ERROR;
          end else begin
            sel_nxt_s  = 1'b0;
            vout_nxt_s = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        if (err_clr && !valid_0 && !valid_1) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Controller registers: state, select, merged valid, counters, status flags
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_r     <= ST_IDLE;
      sel_r       <= 1'b0;
      vout_r      <= 1'b0;
      align_cnt_r <= {ACW{1'b0}};
      word_cnt_r  <= {CNT_W{1'b0}};
      active_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sel_r       <= sel_nxt_s;
      vout_r      <= vout_nxt_s;
      align_cnt_r <= align_nxt_s;
      active_r    <= (state_nxt_s == ST_ACTIVE);
      err_r       <= (state_nxt_s == ST_ERROR);
      if (vout_nxt_s) begin
        word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        word_cnt_r <= word_cnt_r;
      end
    end
  end

`ifdef UNSTRIPE_CTRL_ERRCNT_EN
  logic       enter_err_s;
  logic [7:0] err_cnt_r;

  // An error entry is a move into ERROR from any other state
  always_comb begin
    enter_err_s = (state_nxt_s == ST_ERROR) && (state_r != ST_ERROR);
  end

  // Saturating count of error entries
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      err_cnt_r <= 8'd0;
    end else if (enter_err_s) begin
      err_cnt_r <= sat_inc8(err_cnt_r);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

  assign state        = state_r;
  assign sel          = sel_r;
  assign valid_out    = vout_r;
  assign active       = active_r;
  assign err_misalign = err_r;
  assign word_cnt     = word_cnt_r;

endmodule

// File: tb/tb_unstripe_ctrl.sv
// Self-checking bench for unstripe_ctrl: a directed vector table, hand-written
// wrap/reset/error-count sequences, and randomized lane valids checked
// against a behavioural model of the controller.
module tb_unstripe_ctrl;

  localparam int AC = 2;
  localparam int SK = 4;
  localparam int CW = 4;

  logic          clk_2f;
  logic          reset_L;
  logic          valid_0;
  logic          valid_1;
  logic          err_clr;
  logic          sel;
  logic          valid_out;
  logic          active;
  logic          err_misalign;
  logic [CW-1:0] word_cnt;
  logic [1:0]    state;
`ifdef UNSTRIPE_CTRL_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  int total;
  int bad;

  unstripe_ctrl #(.ALIGN_CYCLES(AC), .SKEW_MAX(SK), .CNT_W(CW)) dut (
    .clk_2f       (clk_2f),
    .reset_L      (reset_L),
    .valid_0      (valid_0),
    .valid_1      (valid_1),
    .err_clr      (err_clr),
    .sel          (sel),
    .valid_out    (valid_out),
    .active       (active),
    .err_misalign (err_misalign),
    .word_cnt     (word_cnt),
    .state        (state)
`ifdef UNSTRIPE_CTRL_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  typedef struct {
    logic v0;
    logic v1;
    logic clr;
    int   st;
    int   sl;
    int   vo;
    int   cnt;
  } vec_t;

  vec_t tbl[$];

  // behavioural model: mode in output encoding, pair progress as a cycle count
  int m_mode;
  int m_align;
  int m_phase;
  int m_vout;
  int m_words;
  int m_errs;

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic v0, input logic v1, input logic clr,
                     input int st, input int sl, input int vo, input int cnt);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.clr = clr;
    v.st = st; v.sl = sl; v.vo = vo; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic m_reset();
    m_mode = 0; m_align = 0; m_phase = 0; m_vout = 0; m_words = 0; m_errs = 0;
  endtask

  task automatic m_step(input bit v0, input bit v1, input bit clr);
    int prev;
    prev = m_mode;
    m_vout = 0;
    case (m_mode)
      0: begin
        if (v0) begin m_mode = 1; m_align = 1; end
        else if (v1) m_mode = 3;
      end
      1: begin
        if (!v0 && !v1) m_mode = 0;
        else if (!v0) m_mode = 3;
        else if (m_align >= AC && v1) begin m_mode = 2; m_phase = 0; end
        else if (m_align == SK) m_mode = 3;
        else m_align = m_align + 1;
      end
      2: begin
        if (m_phase % 2 == 0) begin
          if (!v0 && !v1) m_mode = 0;
          else if (!v0) m_mode = 3;
          else begin m_vout = 1; m_phase = m_phase + 1; end
        end else begin
          if (!v1) m_mode = 3;
          else begin m_vout = 1; m_phase = m_phase + 1; end
        end
      end
      3: begin
        if (clr && !v0 && !v1) m_mode = 0;
      end
      default: m_mode = 0;
    endcase
    if (m_vout == 1) m_words = (m_words + 1) % (1 << CW);
    if (m_mode == 3 && prev != 3 && m_errs < 255) m_errs = m_errs + 1;
  endtask

  task automatic m_compare(input string tag);
    chk({tag, ".state"}, int'(state), m_mode);
    chk({tag, ".sel"}, int'(sel), (m_mode == 2) ? (m_phase % 2) : 0);
    chk({tag, ".valid_out"}, int'(valid_out), m_vout);
    chk({tag, ".active"}, int'(active), (m_mode == 2) ? 1 : 0);
    chk({tag, ".err_misalign"}, int'(err_misalign), (m_mode == 3) ? 1 : 0);
    chk({tag, ".word_cnt"}, int'(word_cnt), m_words);
`ifdef UNSTRIPE_CTRL_ERRCNT_EN
    chk({tag, ".err_cnt"}, int'(err_cnt), m_errs);
`endif
  endtask

  // drive at negedge, clock once, sample at the following negedge
  task automatic cyc(input logic v0, input logic v1, input logic clr);
    valid_0 = v0; valid_1 = v1; err_clr = clr;
    @(posedge clk_2f);
    @(negedge clk_2f);
  endtask

  task automatic do_reset();
    valid_0 = 1'b0; valid_1 = 1'b0; err_clr = 1'b0;
    reset_L = 1'b0;
    @(negedge clk_2f);
    reset_L = 1'b1;
    m_reset();
  endtask

  initial begin
    total = 0;
    bad = 0;
    valid_0 = 1'b0; valid_1 = 1'b0; err_clr = 1'b0;
    reset_L = 1'b0;
    m_reset();
    repeat (2) @(negedge clk_2f);

    // reset state
    chk("rst.state", int'(state), 0);
    chk("rst.sel", int'(sel), 0);
    chk("rst.valid_out", int'(valid_out), 0);
    chk("rst.active", int'(active), 0);
    chk("rst.err_misalign", int'(err_misalign), 0);
    chk("rst.word_cnt", int'(word_cnt), 0);
    reset_L = 1'b1;

    // clean start, clean stop, incomplete pair, error clear, skew timeout
    add(1,0,0, 1,0,0,0); add(1,1,0, 1,0,0,0); add(1,1,0, 2,0,0,0);
    add(1,1,0, 2,1,1,1); add(1,1,0, 2,0,1,2); add(1,1,0, 2,1,1,3);
    add(1,1,0, 2,0,1,4); add(0,0,0, 0,0,0,4); add(0,0,0, 0,0,0,4);
    add(1,1,0, 1,0,0,4); add(1,1,0, 1,0,0,4); add(1,1,0, 2,0,0,4);
    add(1,1,0, 2,1,1,5); add(1,0,0, 3,0,0,5); add(1,1,1, 3,0,0,5);
    add(0,0,1, 0,0,0,5); add(1,0,0, 1,0,0,5); add(1,0,0, 1,0,0,5);
    add(1,0,0, 1,0,0,5); add(1,0,0, 1,0,0,5); add(1,0,0, 3,0,0,5);
    add(0,0,0, 3,0,0,5); add(0,0,1, 0,0,0,5); add(0,1,0, 3,0,0,5);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v0, tbl[i].v1, tbl[i].clr);
      chk($sformatf("vec%0d.state", i), int'(state), tbl[i].st);
      chk($sformatf("vec%0d.sel", i), int'(sel), tbl[i].sl);
      chk($sformatf("vec%0d.valid_out", i), int'(valid_out), tbl[i].vo);
      chk($sformatf("vec%0d.word_cnt", i), int'(word_cnt), tbl[i].cnt);
      chk($sformatf("vec%0d.active", i), int'(active), (tbl[i].st == 2) ? 1 : 0);
      chk($sformatf("vec%0d.err_misalign", i), int'(err_misalign), (tbl[i].st == 3) ? 1 : 0);
    end

`ifdef UNSTRIPE_CTRL_ERRCNT_EN
    chk("errcnt.three", int'(err_cnt), 3);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("errcnt.hold_state", int'(state), 3);
    chk("errcnt.hold", int'(err_cnt), 3);
`endif

    // wrap: 17 merged words on a 4-bit counter, then async reset mid-stream
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("wrap.active", int'(state), 2);
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk($sformatf("wrap.cnt%0d", i + 1), int'(word_cnt), (i + 1) % 16);
    end
    #2;
    reset_L = 1'b0;
    #1;
    chk("async_rst.state", int'(state), 0);
    chk("async_rst.sel", int'(sel), 0);
    chk("async_rst.valid_out", int'(valid_out), 0);
    chk("async_rst.active", int'(active), 0);
    chk("async_rst.err_misalign", int'(err_misalign), 0);
    chk("async_rst.word_cnt", int'(word_cnt), 0);
`ifdef UNSTRIPE_CTRL_ERRCNT_EN
    chk("async_rst.err_cnt", int'(err_cnt), 0);
`endif
    @(negedge clk_2f);
    do_reset();

    // randomized lane valids against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      bit v0;
      bit v1;
      bit clr;
      r = $urandom_range(0, 15);
      v0 = (r <= 11);
      v1 = (r <= 10) || (r == 12);
      clr = (r >= 13) ? 1'b1 : ($urandom_range(0, 3) == 0);
      cyc(v0, v1, clr);
      m_step(v0, v1, clr);
      m_compare($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
